// File: rtl/mem_timeout_bridge.sv
// Registered CPU-to-interconnect memory bridge with an optional access timeout.
// Define MEM_TIMEOUT_EN to enable the timeout counter and sticky fault logging.
module mem_timeout_bridge #(
  parameter int          TIMEOUT_CYCLES = 1024,
  parameter int          CNT_W          = 11,
  parameter logic [31:0] ERR_RDATA      = 32'hDEADBEEF
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        s_mem_valid,
  output logic        s_mem_ready,
  input  logic [31:0] s_mem_addr,
  input  logic [31:0] s_mem_wdata,
  input  logic [3:0]  s_mem_wstrb,
  output logic [31:0] s_mem_rdata,
  output logic        m_mem_valid,
  input  logic        m_mem_ready,
  output logic [31:0] m_mem_addr,
  output logic [31:0] m_mem_wdata,
  output logic [3:0]  m_mem_wstrb,
  input  logic [31:0] m_mem_rdata,
  input  logic        fault_clr,
  output logic        fault_o,
  output logic [31:0] fault_addr
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic        m_valid_q, m_valid_d;
  logic        s_ready_q, s_ready_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic [31:0] rdata_q, rdata_d;
  logic        timeout;

`ifdef MEM_TIMEOUT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             fault_q, fault_d;
  logic [31:0]      fault_addr_q, fault_addr_d;

  // A ready in the last REQ cycle takes priority, so it is never a timeout.
  assign timeout = (state_q == REQ) && !m_mem_ready
                   && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (state_q == IDLE) begin
      cnt_d = '0;
    end else if ((state_q == REQ) && !m_mem_ready && !timeout) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_comb begin
    fault_d      = fault_q;
    fault_addr_d = fault_addr_q;
    if (timeout) begin
      fault_d = 1'b1;
      if (!fault_q || fault_clr) begin
        fault_addr_d = addr_q;
      end
    end else if (fault_clr) begin
      fault_d      = 1'b0;
      fault_addr_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      cnt_q        <= '0;
      fault_q      <= 1'b0;
      fault_addr_q <= '0;
    end else begin
      cnt_q        <= cnt_d;
      fault_q      <= fault_d;
      fault_addr_q <= fault_addr_d;
    end
  end

  assign fault_o    = fault_q;
  assign fault_addr = fault_addr_q;
`else
  logic unused_cfg;

  assign timeout    = 1'b0;
  assign fault_o    = 1'b0;
  assign fault_addr = '0;
  assign unused_cfg = ^{ERR_RDATA, 32'(TIMEOUT_CYCLES), 32'(CNT_W), fault_clr};
`endif

  always_comb begin
    state_d   = state_q;
    m_valid_d = m_valid_q;
    s_ready_d = 1'b0;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    rdata_d   = rdata_q;
    case (state_q)
      IDLE: begin
        if (s_mem_valid) begin
          addr_d    = s_mem_addr;
          wdata_d   = s_mem_wdata;
          wstrb_d   = s_mem_wstrb;
          m_valid_d = 1'b1;
          state_d   = REQ;
        end
      end
      REQ: begin
        if (m_mem_ready) begin
          rdata_d   = m_mem_rdata;
          m_valid_d = 1'b0;
          s_ready_d = 1'b1;
          state_d   = RESP;
        end else if (timeout) begin
`ifdef MEM_TIMEOUT_EN
          rdata_d   = ERR_RDATA;
`endif
          m_valid_d = 1'b0;
          s_ready_d = 1'b1;
          state_d   = RESP;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        m_valid_d = 1'b0;
        state_d   = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q   <= IDLE;
      m_valid_q <= 1'b0;
      s_ready_q <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      m_valid_q <= m_valid_d;
      s_ready_q <= s_ready_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      rdata_q   <= rdata_d;
    end
  end

  assign s_mem_ready = s_ready_q;
  assign s_mem_rdata = rdata_q;
  assign m_mem_valid = m_valid_q;
  assign m_mem_addr  = addr_q;
  assign m_mem_wdata = wdata_q;
  assign m_mem_wstrb = wstrb_q;

endmodule

// File: tb/tb_mem_timeout_bridge.sv
// Scoreboard bench for mem_timeout_bridge; the sequence adapts to MEM_TIMEOUT_EN.
module tb_mem_timeout_bridge;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        s_mem_valid = 1'b0;
  logic        s_mem_ready;
  logic [31:0] s_mem_addr = '0;
  logic [31:0] s_mem_wdata = '0;
  logic [3:0]  s_mem_wstrb = '0;
  logic [31:0] s_mem_rdata;
  logic        m_mem_valid;
  logic        m_mem_ready = 1'b0;
  logic [31:0] m_mem_addr;
  logic [31:0] m_mem_wdata;
  logic [3:0]  m_mem_wstrb;
  logic [31:0] m_mem_rdata = '0;
  logic        fault_clr = 1'b0;
  logic        fault_o;
  logic [31:0] fault_addr;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [31:0] rdata;
    logic        fault;
    logic [31:0] faddr;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;

  mem_timeout_bridge #(
    .TIMEOUT_CYCLES(16),
    .CNT_W(5),
    .ERR_RDATA(32'hDEADBEEF)
  ) dut (
    .clk(clk),
    .resetn(resetn),
    .s_mem_valid(s_mem_valid),
    .s_mem_ready(s_mem_ready),
    .s_mem_addr(s_mem_addr),
    .s_mem_wdata(s_mem_wdata),
    .s_mem_wstrb(s_mem_wstrb),
    .s_mem_rdata(s_mem_rdata),
    .m_mem_valid(m_mem_valid),
    .m_mem_ready(m_mem_ready),
    .m_mem_addr(m_mem_addr),
    .m_mem_wdata(m_mem_wdata),
    .m_mem_wstrb(m_mem_wstrb),
    .m_mem_rdata(m_mem_rdata),
    .fault_clr(fault_clr),
    .fault_o(fault_o),
    .fault_addr(fault_addr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  // Monitor: every upstream completion must match the oldest queued expectation.
  always @(negedge clk) begin
    if (resetn && s_mem_ready) begin
      if (sb_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_ready: got s_mem_ready=1 expected no response");
      end else begin
        mon_e = sb_q.pop_front();
        chk("resp rdata", s_mem_rdata, mon_e.rdata);
        chk("resp fault_o", {31'd0, fault_o}, {31'd0, mon_e.fault});
        chk("resp fault_addr", fault_addr, mon_e.faddr);
      end
    end
  end

  function automatic void expect_resp(input logic [31:0] rdata, input logic fault,
                                      input logic [31:0] faddr);
    exp_t e;
    e.rdata = rdata;
    e.fault = fault;
    e.faddr = faddr;
    sb_q.push_back(e);
  endfunction

  // Drives one request and acts as the slave; ready_at=0 means never acknowledge.
  task automatic access(input string tag, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] wstrb, input int ready_at, input logic [31:0] rdata,
                        input int exp_req, input int budget, input bit expect_done);
    int req_cycles = 0;
    int edges = 0;
    bit done = 1'b0;
    bit stable = 1'b1;
    s_mem_valid = 1'b1;
    s_mem_addr  = addr;
    s_mem_wdata = wdata;
    s_mem_wstrb = wstrb;
    while (!done && edges < budget) begin
      if (m_mem_valid) begin
        req_cycles++;
        if (m_mem_addr !== addr || m_mem_wdata !== wdata || m_mem_wstrb !== wstrb) stable = 1'b0;
        s_mem_addr  = ~addr;
        s_mem_wdata = ~wdata;
        s_mem_wstrb = ~wstrb;
        m_mem_ready = (req_cycles == ready_at);
        m_mem_rdata = m_mem_ready ? rdata : 32'h0BAD0BAD;
      end else begin
        m_mem_ready = 1'b0;
      end
      @(posedge clk);
      #1;
      edges++;
      if (s_mem_ready) done = 1'b1;
    end
    m_mem_ready = 1'b0;
    s_mem_valid = 1'b0;
    chk({tag, " m_valid_cycles"}, 32'(req_cycles), 32'(exp_req));
    chk({tag, " m_stable"}, {31'd0, stable}, 32'd1);
    if (expect_done) chk({tag, " latency"}, 32'(edges), 32'(exp_req + 1));
    else chk({tag, " hang"}, {31'd0, done}, 32'd0);
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic apply_reset(input string tag);
    resetn = 1'b0;
    @(posedge clk);
    #1;
    chk({tag, " m_mem_valid"}, {31'd0, m_mem_valid}, 32'd0);
    chk({tag, " s_mem_ready"}, {31'd0, s_mem_ready}, 32'd0);
    chk({tag, " m_mem_addr"}, m_mem_addr, 32'd0);
    chk({tag, " m_mem_wdata"}, m_mem_wdata, 32'd0);
    chk({tag, " m_mem_wstrb"}, {28'd0, m_mem_wstrb}, 32'd0);
    chk({tag, " s_mem_rdata"}, s_mem_rdata, 32'd0);
    chk({tag, " fault_o"}, {31'd0, fault_o}, 32'd0);
    chk({tag, " fault_addr"}, fault_addr, 32'd0);
    resetn = 1'b1;
  endtask

  task automatic pulse_clr(input logic [31:0] exp_faddr, input logic exp_fault);
    fault_clr = 1'b1;
    @(posedge clk);
    #1;
    fault_clr = 1'b0;
    chk("clr fault_o", {31'd0, fault_o}, {31'd0, exp_fault});
    chk("clr fault_addr", fault_addr, exp_faddr);
  endtask

  task automatic late_ack();
    m_mem_ready = 1'b1;
    m_mem_rdata = 32'h99999999;
    idle_cycles(2);
    m_mem_ready = 1'b0;
    chk("late_ack m_mem_valid", {31'd0, m_mem_valid}, 32'd0);
    chk("late_ack s_mem_ready", {31'd0, s_mem_ready}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_cycles(2);
    apply_reset("reset");
    idle_cycles(1);

    expect_resp(32'h12345678, 1'b0, 32'h0);
    access("read1", 32'h10000008, 32'h0, 4'h0, 3, 32'h12345678, 3, 40, 1'b1);
    idle_cycles(1);

    expect_resp(32'h11112222, 1'b0, 32'h0);
    access("write2", 32'h20000004, 32'hA5A5A5A5, 4'hF, 1, 32'h11112222, 1, 40, 1'b1);
    idle_cycles(1);

    expect_resp(32'hCAFEF00D, 1'b0, 32'h0);
    access("edge16", 32'h30000010, 32'h0, 4'h0, 16, 32'hCAFEF00D, 16, 40, 1'b1);
    idle_cycles(1);

`ifdef MEM_TIMEOUT_EN
    expect_resp(32'hDEADBEEF, 1'b1, 32'h7F000000);
    access("tmo3", 32'h7F000000, 32'h0, 4'h0, 0, 32'h0, 16, 40, 1'b1);
    idle_cycles(1);
    pulse_clr(32'h0, 1'b0);

    expect_resp(32'hDEADBEEF, 1'b1, 32'h50000000);
    access("tmo5a", 32'h50000000, 32'h0, 4'h0, 0, 32'h0, 16, 40, 1'b1);
    late_ack();
    expect_resp(32'hDEADBEEF, 1'b1, 32'h50000000);
    access("tmo5b", 32'h60000000, 32'h01020304, 4'h3, 0, 32'h0, 16, 40, 1'b1);
    late_ack();
    pulse_clr(32'h0, 1'b0);

    expect_resp(32'hDEADBEEF, 1'b1, 32'h70000000);
    access("tmo6", 32'h70000000, 32'h0, 4'h0, 0, 32'h0, 16, 40, 1'b1);
    idle_cycles(1);

    access("midreq", 32'h40000000, 32'h0, 4'h0, 0, 32'h0, 4, 5, 1'b0);
    apply_reset("midreq_reset");
`else
    access("hang3", 32'h7F000000, 32'h0, 4'h0, 0, 32'h0, 39, 40, 1'b0);
    chk("hang3 m_mem_valid", {31'd0, m_mem_valid}, 32'd1);
    pulse_clr(32'h0, 1'b0);
    apply_reset("midreq_reset");
    late_ack();
`endif

    idle_cycles(1);
    expect_resp(32'h87654321, 1'b0, 32'h0);
    access("post_reset", 32'h10000000, 32'h0, 4'h0, 2, 32'h87654321, 2, 40, 1'b1);
    idle_cycles(3);

    chk("scoreboard empty", 32'(sb_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
